// File: rtl/cpu_trace_pkg.sv
// cpu_trace_pkg: shared state encoding, stop causes and ring read-pointer helper
package cpu_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_LIMIT = 2'd1;
    localparam logic [1:0] CAUSE_BP    = 2'd2;
    localparam logic [1:0] CAUSE_STEP  = 2'd3;

    // depth is a power of two, so unsigned wrap of wr - cnt stays correct modulo depth
    function automatic int unsigned rd_offset(input int unsigned wr, input int unsigned cnt,
                                              input int unsigned idx, input int unsigned depth);
        return (wr - cnt + idx) % depth;
    endfunction

endpackage

// File: rtl/trace_ring_buffer.sv
// trace_ring_buffer: DEPTH-entry overwrite-oldest ring with combinational read, index 0 = oldest
module trace_ring_buffer import cpu_trace_pkg::*; #(
    parameter int DEPTH = 16,
    parameter int W     = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       we,
    input  logic [W-1:0]               wdata,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (we)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (we) begin
            wr_ptr <= wr_ptr + AW'(1);
            count  <= (count == (AW+1)'(DEPTH)) ? count : count + (AW+1)'(1);
        end
    end

    always_comb begin
        rd_ptr = AW'(rd_offset(32'(wr_ptr), 32'(count), 32'(rd_idx), DEPTH));
        rdata  = mem[rd_ptr];
    end

endmodule

// File: rtl/cpu_run_trace_ctrl.sv
// cpu_run_trace_ctrl: cycle-limited run control with PC breakpoints and trace; CPU_TRACE_STEP_EN adds single-step
module cpu_run_trace_ctrl import cpu_trace_pkg::*; #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 16,
    parameter int CYCLE_W = 16,
    parameter int NUM_BP  = 2
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       start,
`ifdef CPU_TRACE_STEP_EN
    input  logic                                       step,
`endif
    input  logic [CYCLE_W-1:0]                         max_cycles,
    input  logic [NUM_BP*PC_W-1:0]                     bp_addr,
    input  logic [NUM_BP-1:0]                          bp_en,
    input  logic [PC_W-1:0]                            cpu_pc,
    input  logic [INSTR_W-1:0]                         cpu_instr,
    output logic                                       cpu_run,
    output logic                                       busy,
    output logic                                       done,
    output logic [1:0]                                 stop_cause,
    output logic [((NUM_BP > 1) ? $clog2(NUM_BP) : 1)-1:0] bp_hit_idx,
    output logic [CYCLE_W-1:0]                         cycle_count,
    output logic [$clog2(DEPTH):0]                     trace_count,
    input  logic [$clog2(DEPTH)-1:0]                   rd_idx,
    output logic [PC_W-1:0]                            rd_pc,
    output logic [INSTR_W-1:0]                         rd_instr
);
    localparam int BW = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

    state_t             state, state_n;
    logic [CYCLE_W-1:0] max_lat;
    logic [PC_W-1:0]    halt_pc;
    logic               skip;
    logic               accept, step_go, bp_match, limit_hit;
    logic [BW-1:0]      bp_idx;

`ifdef CPU_TRACE_STEP_EN
    assign step_go = step && !start && state != ST_RUN;
`else
    assign step_go = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    // the breakpoint that caused the last halt is masked for one cycle so a restart makes progress
    always_comb begin
        bp_match = 1'b0;
        bp_idx   = '0;
        for (int k = NUM_BP - 1; k >= 0; k--) begin
            if (bp_en[k] && cpu_pc == bp_addr[k*PC_W +: PC_W] &&
                !(skip && bp_addr[k*PC_W +: PC_W] == halt_pc)) begin
                bp_match = 1'b1;
                bp_idx   = BW'(k);
            end
        end
        bp_match  = bp_match && state == ST_RUN;
        accept    = start && state != ST_RUN;
        cpu_run   = (state == ST_RUN && !bp_match) || step_go;
        limit_hit = state == ST_RUN && cpu_run && cycle_count + CYCLE_W'(1) == max_lat;
        busy      = state == ST_RUN;
        done      = state == ST_HALT;
        state_n   = accept ? ((max_cycles == '0) ? ST_HALT : ST_RUN) :
                    (step_go || bp_match || limit_hit) ? ST_HALT : state;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            max_lat     <= '0;
            cycle_count <= '0;
            stop_cause  <= CAUSE_NONE;
            bp_hit_idx  <= '0;
            halt_pc     <= '0;
            skip        <= 1'b0;
        end else if (accept) begin
            max_lat     <= max_cycles;
            cycle_count <= '0;
            stop_cause  <= (max_cycles == '0) ? CAUSE_LIMIT : CAUSE_NONE;
            bp_hit_idx  <= '0;
            skip        <= state == ST_HALT && stop_cause == CAUSE_BP;
        end else begin
            skip <= 1'b0;
            if (cpu_run)
                cycle_count <= cycle_count + CYCLE_W'(1);
            if (step_go) begin
                stop_cause <= CAUSE_STEP;
            end else if (bp_match) begin
                stop_cause <= CAUSE_BP;
                bp_hit_idx <= bp_idx;
                halt_pc    <= cpu_pc;
            end else if (limit_hit) begin
                stop_cause <= CAUSE_LIMIT;
            end
        end
    end

    trace_ring_buffer #(
        .DEPTH (DEPTH),
        .W     (PC_W + INSTR_W)
    ) u_ring (
        .clk    (clk),
        .reset  (reset),
        .clr    (accept),
        .we     (cpu_run),
        .wdata  ({cpu_pc, cpu_instr}),
        .rd_idx (rd_idx),
        .rdata  ({rd_pc, rd_instr}),
        .count  (trace_count)
    );

endmodule

// File: tb/tb_cpu_run_trace_ctrl.sv
// tb_cpu_run_trace_ctrl: directed and random runs checked against a sequential execution model
module tb_cpu_run_trace_ctrl;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
`ifdef CPU_TRACE_STEP_EN
    logic        step = 1'b0;
`endif
    logic [15:0] max_cycles = '0;
    logic [31:0] bpa [2];
    logic [63:0] bp_addr;
    logic [1:0]  bp_en = '0;
    logic [31:0] cpu_pc = '0;
    logic [31:0] cpu_instr = '0;
    logic        cpu_run, busy, done;
    logic [1:0]  stop_cause;
    logic [0:0]  bp_hit_idx;
    logic [15:0] cycle_count;
    logic [4:0]  trace_count;
    logic [3:0]  rd_idx = '0;
    logic [31:0] rd_pc, rd_instr;

    int n_cmp = 0, n_err = 0, run_cnt = 0;
    int m_cyc, m_cause, m_idx, m_halt_pc;
    bit m_last_bp = 0;
    logic [31:0] m_pcs[$], m_ins[$];

    assign bp_addr = {bpa[1], bpa[0]};

    always #5 clk = ~clk;

    cpu_run_trace_ctrl #(.PC_W(32), .INSTR_W(32), .DEPTH(DEPTH), .CYCLE_W(16), .NUM_BP(2)) dut (
        .clk(clk), .reset(reset), .start(start),
`ifdef CPU_TRACE_STEP_EN
        .step(step),
`endif
        .max_cycles(max_cycles), .bp_addr(bp_addr), .bp_en(bp_en),
        .cpu_pc(cpu_pc), .cpu_instr(cpu_instr), .cpu_run(cpu_run), .busy(busy), .done(done),
        .stop_cause(stop_cause), .bp_hit_idx(bp_hit_idx), .cycle_count(cycle_count),
        .trace_count(trace_count), .rd_idx(rd_idx), .rd_pc(rd_pc), .rd_instr(rd_instr)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] p);
        return {p[15:0], p[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_pc(input logic [31:0] p);
        cpu_pc = p;
        cpu_instr = instr_of(p);
    endtask

    // one clock: sample cpu_run mid-cycle, let the edge happen, then advance the fake CPU
    task automatic do_cycle();
        bit ran;
        @(negedge clk);
        ran = cpu_run;
        run_cnt += int'(ran);
        @(posedge clk);
        #1;
        if (ran) set_pc(cpu_pc + 32'd4);
    endtask

    task automatic model_push(input logic [31:0] p);
        m_pcs.push_back(p);
        m_ins.push_back(instr_of(p));
        if (m_pcs.size() > DEPTH) begin
            void'(m_pcs.pop_front());
            void'(m_ins.pop_front());
        end
    endtask

    // executes PCs sequentially from the current one until limit or an enabled breakpoint
    task automatic model_run(input int mx);
        logic [31:0] p;
        int hit;
        p = cpu_pc;
        m_cyc = 0;
        m_cause = 0;
        m_idx = 0;
        m_pcs.delete();
        m_ins.delete();
        if (mx == 0) m_cause = 1;
        while (m_cause == 0) begin
            hit = -1;
            for (int k = 1; k >= 0; k--)
                if (bp_en[k] && bpa[k] == p && !(m_last_bp && m_cyc == 0 && bpa[k] == m_halt_pc))
                    hit = k;
            if (hit >= 0) begin
                m_cause = 2;
                m_idx = hit;
            end else begin
                model_push(p);
                m_cyc++;
                p += 32'd4;
                if (m_cyc == mx) m_cause = 1;
            end
        end
        m_last_bp = (m_cause == 2);
        m_halt_pc = p;
    endtask

    task automatic check_halt(input string tag);
        check({tag, ".done"}, done, 1);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".cause"}, stop_cause, m_cause);
        check({tag, ".bp_idx"}, bp_hit_idx, m_idx);
        check({tag, ".cycles"}, cycle_count, m_cyc);
        check({tag, ".tcount"}, trace_count, m_pcs.size());
        for (int i = 0; i < m_pcs.size(); i++) begin
            rd_idx = 4'(i);
            #1;
            check({tag, ".rd_pc"}, rd_pc, m_pcs[i]);
            check({tag, ".rd_instr"}, rd_instr, m_ins[i]);
        end
    endtask

    task automatic run_and_check(input string tag, input int mx);
        int n;
        model_run(mx);
        max_cycles = 16'(mx);
        run_cnt = 0;
        start = 1'b1;
        do_cycle();
        start = 1'b0;
        n = 0;
        while (!done && n < 300) begin
            do_cycle();
            n++;
        end
        check({tag, ".run_cycles"}, run_cnt, m_cyc);
        check_halt(tag);
        repeat (2) do_cycle();
        check({tag, ".hold_cycles"}, cycle_count, m_cyc);
        check({tag, ".hold_cause"}, stop_cause, m_cause);
    endtask

    initial begin
        bpa[0] = '0;
        bpa[1] = '0;
        set_pc(32'd0);
        repeat (2) do_cycle();
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.cpu_run", cpu_run, 0);
        check("rst.cycles", cycle_count, 0);
        check("rst.tcount", trace_count, 0);
        check("rst.cause", stop_cause, 0);
        reset = 1'b1;
        do_cycle();

        run_and_check("lim5", 5);
        rd_idx = 4'd4;
        #1;
        check("lim5.pc_idx4", rd_pc, 32'd16);

`ifdef CPU_TRACE_STEP_EN
        repeat (2) begin
            model_push(cpu_pc);
            m_cyc++;
            step = 1'b1;
            do_cycle();
            step = 1'b0;
        end
        m_cause = 3;
        m_last_bp = 0;
        check_halt("step");
`endif

        set_pc(32'd0);
        run_and_check("wrap20", 20);
        rd_idx = 4'd0;
        #1;
        check("wrap20.oldest", rd_pc, 32'd16);
        rd_idx = 4'd15;
        #1;
        check("wrap20.newest", rd_pc, 32'd76);

        set_pc(32'd0);
        bpa[0] = 32'd12;
        bp_en = 2'b01;
        run_and_check("bp12", 100);
        check("bp12.pc_held", cpu_pc, 32'd12);
        run_and_check("bp12.restart", 100);

        set_pc(32'd0);
        bpa[0] = 32'd8;
        bpa[1] = 32'd8;
        bp_en = 2'b11;
        run_and_check("bp_both", 100);
        bp_en = 2'b00;
        run_and_check("max0", 0);

        set_pc(32'd0);
        max_cycles = 16'd100;
        start = 1'b1;
        do_cycle();
        start = 1'b0;
        repeat (7) do_cycle();
        check("mid.cycles_pre", cycle_count, 7);
        reset = 1'b0;
        do_cycle();
        check("mid.busy", busy, 0);
        check("mid.cycles", cycle_count, 0);
        check("mid.tcount", trace_count, 0);
        check("mid.cpu_run", cpu_run, 0);
        reset = 1'b1;
        m_last_bp = 0;

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 1) set_pc(32'($urandom_range(0, 20)) * 32'd4);
            bpa[0] = 32'($urandom_range(0, 40)) * 32'd4;
            bpa[1] = 32'($urandom_range(0, 40)) * 32'd4;
            bp_en = 2'($urandom_range(0, 3));
            run_and_check("rand", $urandom_range(0, 40));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_run_trace_ctrl.md
Name: cpu_run_trace_ctrl

Overview:
Synthesizable run-control and trace unit for the MIPS CPU; replaces fixed-count free-running clocking with parametrised, controllable execution.
- Gates the CPU with a run enable for up to a programmed cycle count.
- Halts early on PC breakpoints.
- Records the last DEPTH (PC, instruction) pairs in a ring buffer, readable after halt.
- Sits between the top-level bench/debug host and the CPU's PC and instruction-memory outputs.

Parameters:
PC_W, 32, width of program counter
INSTR_W, 32, width of instruction word
DEPTH, 16, trace entries; power of two, >= 2
CYCLE_W, 16, width of cycle limit and counter
NUM_BP, 2, number of PC breakpoint comparators

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-low reset
start  in  1  pulse; begins a run from IDLE or HALT
max_cycles  in  CYCLE_W  cycle limit, sampled on accepted start
bp_addr  in  NUM_BP*PC_W  breakpoint PCs, slot k at [k*PC_W +: PC_W]
bp_en  in  NUM_BP  per-slot breakpoint enable
cpu_pc  in  PC_W  current CPU program counter
cpu_instr  in  INSTR_W  current fetched instruction
cpu_run  out  1  CPU clock-enable
busy  out  1  high in RUN
done  out  1  high in HALT
stop_cause  out  2  0 none, 1 limit, 2 breakpoint, 3 step
bp_hit_idx  out  clog2(NUM_BP) (min 1)  lowest matching slot at breakpoint stop
cycle_count  out  CYCLE_W  cycles executed this run
trace_count  out  clog2(DEPTH)+1  valid trace entries, saturates at DEPTH
rd_idx  in  clog2(DEPTH)  trace read index, 0 = oldest
rd_pc  out  PC_W  PC of entry rd_idx (combinational)
rd_instr  out  INSTR_W  instruction of entry rd_idx (combinational)

Behaviour:
- Reset (reset=0 at clk edge), overrides everything including mid-run:
  - state IDLE; cycle_count, trace_count, write pointer, stop_cause, bp_hit_idx all 0.
  - cpu_run, busy, done all 0.
  - Trace RAM contents undefined.
- States:
  - IDLE: start -> RUN.
  - RUN: see stop rules below.
  - HALT: start -> RUN.
  - start while in RUN is ignored.
- Accepted start:
  - latch max_cycles.
  - clear cycle_count, trace_count, write pointer, stop_cause, bp_hit_idx.
  - If latched max_cycles == 0: go directly to HALT, cause 1, zero cycles executed.
- Breakpoints:
  - bp_match = (state == RUN) and any slot k with bp_en[k] and cpu_pc == slot k.
  - cpu_run = (state == RUN) and not bp_match (combinational), so the breakpointed instruction is neither executed nor traced.
  - On bp_match: -> HALT, cause 2, bp_hit_idx = lowest k.
- Each RUN cycle with cpu_run=1:
  - write {cpu_pc, cpu_instr} at the write pointer; pointer increments modulo DEPTH.
  - trace_count += 1, saturating at DEPTH.
  - cycle_count += 1.
  - If the new cycle_count == latched max_cycles: -> HALT, cause 1.
- Precedence: breakpoint is evaluated before execution, so the limit is reached only on executed cycles.
- Ring buffer: once full, the oldest entry is overwritten.
  - Read address = (wr_ptr - trace_count + rd_idx) mod DEPTH.
  - rd_idx >= trace_count returns undefined data.
- Restart from a breakpoint halt:
  - The first RUN cycle ignores breakpoints whose address equals the PC latched at halt (one-cycle skip), so the run makes progress.
  - Only the first cycle is masked.
- Outputs in HALT: done stays 1, and stop_cause/cycle_count hold, until the next accepted start or reset.

Optional Feature:
CPU_TRACE_STEP_EN:
- Defined:
  - adds input step (1 bit).
  - step pulse in HALT or IDLE executes exactly one cycle: cpu_run=1 for that cycle, trace written, cycle_count += 1, breakpoints not checked.
  - Unit then returns to HALT with cause 3, without clearing counters.
  - start has priority over step in the same cycle.
- Undefined: no step port; cause code 3 is never produced.

Decomposition:
- Package cpu_trace_pkg:
  - state encoding IDLE/RUN/HALT.
  - stop-cause constants CAUSE_NONE/LIMIT/BP/STEP.
  - helper function computing the read-pointer offset.
- One sub-module: trace_ring_buffer (parametrised DEPTH/width; write port, combinational read port, pointer and count logic).
- Breakpoint compare stays inline in the top module.

Test Plan:
- max_cycles=5, no bp, PC steps 0,4,8… -> cpu_run high exactly 5 cycles; done=1, cause=1, cycle_count=5, trace_count=5, rd_idx=4 gives pc=16.
- DEPTH=16, max_cycles=20 -> trace_count=16; rd_idx=0 gives pc=16 (oldest surviving), rd_idx=15 gives pc=76.
- bp_en=01, bp_addr[0]=12, max_cycles=100 -> halt with cycle_count=3, cause=2, bp_hit_idx=0; cpu_run low while pc=12. Restart -> pc=12 executes, run continues to limit.
- Both slots=8 enabled -> bp_hit_idx=0. max_cycles=0 -> immediate HALT, cause=1, cycle_count=0, cpu_run never asserted.
- reset=0 during RUN at cycle 7 -> next edge: busy=0, cycle_count=0, trace_count=0, cpu_run=0.
- With CPU_TRACE_STEP_EN: after limit halt at cycle_count=5, two step pulses -> cycle_count=7, cause=3, trace_count=7.
